rgb2gray_pipe: RTL and testbench
================================

Name: rgb2gray_pipe

Overview:
Parametrised, fully pipelined RGB-to-grayscale converter for the Sobel front end, placed between pixel ingest and the line buffers. It replaces fixed shift-add luma with multiply-accumulate against per-beat selectable coefficient sets: BT.601, BT.709, runtime-programmable, or green passthrough. Arithmetic is rounded and saturated. Valid/ready handshakes run on both sides, with a user sideband carried in lockstep for frame and line markers.

Parameters:
WIDTH_P, 8, bits per colour channel and per gray output
COEF_WIDTH_P, 8, fractional bits of coefficients (weight = coef / 2^COEF_WIDTH_P)
USER_WIDTH_P, 2, sideband width carried alongside each pixel (e.g. {sof, eol})

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
valid_i  in  1  upstream pixel valid
ready_o  out  1  block can accept a pixel this cycle
red_i  in  WIDTH_P  red channel
green_i  in  WIDTH_P  green channel
blue_i  in  WIDTH_P  blue channel
mode_i  in  2  0=BT.601, 1=BT.709, 2=programmable, 3=green passthrough
coef_r_i  in  COEF_WIDTH_P+1  programmable red weight, unsigned, max < 2.0
coef_g_i  in  COEF_WIDTH_P+1  programmable green weight
coef_b_i  in  COEF_WIDTH_P+1  programmable blue weight
user_i  in  USER_WIDTH_P  sideband, accepted with the pixel
valid_o  out  1  output pixel valid
ready_i  in  1  downstream ready
gray_o  out  WIDTH_P  grayscale result
user_o  out  USER_WIDTH_P  sideband aligned with gray_o

Behaviour:
- Reset and accept: async assert clears all stage valids, gray_o, and user_o to 0. Pixel accepted when valid_i && ready_o.
- Pipeline: three register stages, each with valid bit.
  - S1 registers the three products and the mode.
  - S2 registers the sum.
  - S3 registers the rounded, saturated result and drives valid_o, gray_o and user_o.
- Coefficient sampling: mode_i and coef_*_i are sampled only at acceptance. Later changes never affect in-flight beats. Mode may change every beat.
- Fixed coefficients: BT.601 and BT.709 weights are localparams, each = round(w*2^COEF_WIDTH_P).
  - BT.601 at COEF_WIDTH_P=8: 77/150/29.
  - BT.709 at COEF_WIDTH_P=8: 54/183/18.
- Products: WIDTH_P+COEF_WIDTH_P+1 bits each.
- Sum: WIDTH_P+COEF_WIDTH_P+3 bits, no overflow possible.
- Rounding: round half up, i.e. add 2^(COEF_WIDTH_P-1), then shift right by COEF_WIDTH_P.
- Saturation: result > 2^WIDTH_P-1 clamps to 2^WIDTH_P-1.
- Mode 3: gray = green_i exactly. The beat still traverses all three stages, so latency is uniform.
- Stage advance: each stage loads when it is empty or the stage after it advances. S3 advances when ready_i, or when valid_o is 0.
- ready_o = ~S1.valid | S1 advances. A combinational path from ready_i to ready_o is permitted; bubbles collapse.
- Latency and throughput: 3 cycles from acceptance to valid_o with ready_i high; 1 pixel/cycle sustained.
- Stall: with ready_i low, S3 holds gray_o, user_o and valid_o stable. Up to 3 beats buffer before ready_o drops. No beat is dropped, duplicated or reordered.
- Simultaneous events: a full pipeline with ready_i high accepts and emits in the same cycle.
- Reset mid-stream: all in-flight beats are discarded. After release, the first output is the first beat accepted after reset.

Test Plan:
- BT.601, (255,0,0) then (0,255,0) then (255,255,255) -> gray_o 77, 149, 255 on cycles 3, 4, 5 after the first accept.
- BT.709, (100,200,50) -> 168. Mode 3, (12,200,7) -> 200. Mode switch on alternate beats yields per-beat correct results.
- Programmable weights 255/255/255 with white -> saturates to 255. Weights 128/0/0 with red=3 -> 2 (1.5 rounds up). Changing coef_*_i after accept leaves the result unchanged.
- Backpressure: send 6 beats back-to-back with ready_i low -> ready_o drops after 3 accepted. Raise ready_i -> all 6 emerge in order with user_o aligned; gray_o stays stable while stalled.
- Random valid_i/ready_i over 10k beats against a reference model -> exact match, no loss or duplication.
- Assert rstn_i with 2 beats in flight -> valid_o=0, gray_o=0 immediately. The next accepted beat emerges 3 cycles after its acceptance.

Source files
------------

// File: rtl/rgb2gray_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : rgb2gray_pipe_if
//  Purpose  : Pixel stream bundle for rgb2gray_pipe. It carries the
//             upstream RGB beat with its per-beat mode, programmable weights
//             and sideband, and the downstream gray beat.
//  Modports : slave  - converter view (consumes RGB, produces gray)
//             master - source/sink view (produces RGB, consumes gray)
//  Signals  : valid_i/ready_o                  upstream handshake
//             red_i/green_i/blue_i             colour channels
//             mode_i                           0=BT.601 1=BT.709 2=prog 3=green
//             coef_r_i/coef_g_i/coef_b_i       programmable weights (Q1.COEF)
//             user_i                           sideband accepted with the pixel
//             valid_o/ready_i                  downstream handshake
//             gray_o/user_o                    result and aligned sideband
//  Revision : 1.0 - initial release
// ============================================================================
interface rgb2gray_pipe_if #(
   parameter int WIDTH_P      = 8,
   parameter int COEF_WIDTH_P = 8,
   parameter int USER_WIDTH_P = 2
);
   logic                    valid_i;
   logic                    ready_o;
   logic [WIDTH_P-1:0]      red_i;
   logic [WIDTH_P-1:0]      green_i;
   logic [WIDTH_P-1:0]      blue_i;
   logic [1:0]              mode_i;
   logic [COEF_WIDTH_P:0]   coef_r_i;
   logic [COEF_WIDTH_P:0]   coef_g_i;
   logic [COEF_WIDTH_P:0]   coef_b_i;
   logic [USER_WIDTH_P-1:0] user_i;
   logic                    valid_o;
   logic                    ready_i;
   logic [WIDTH_P-1:0]      gray_o;
   logic [USER_WIDTH_P-1:0] user_o;

   modport slave (
      input  valid_i, red_i, green_i, blue_i, mode_i,
             coef_r_i, coef_g_i, coef_b_i, user_i, ready_i,
      output ready_o, valid_o, gray_o, user_o
   );

   modport master (
      output valid_i, red_i, green_i, blue_i, mode_i,
             coef_r_i, coef_g_i, coef_b_i, user_i, ready_i,
      input  ready_o, valid_o, gray_o, user_o
   );
endinterface
`default_nettype wire

// File: rtl/rgb2gray_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : rgb2gray_pipe
//  Purpose  : Three-stage RGB-to-grayscale converter with per-beat
//             selectable weights (BT.601, BT.709, programmable, green
//             passthrough), round-half-up and saturation, valid/ready on
//             both sides and a sideband carried in lockstep.
//  Ports    : clk_i  - clock
//             rstn_i - asynchronous active-low reset
//             px     - rgb2gray_pipe_if.slave pixel stream bundle
//  Stages   : S1 products + mode, S2 sum, S3 rounded/saturated gray.
//  Revision : 1.0 - initial release
// ============================================================================
module rgb2gray_pipe #(
   parameter int WIDTH_P      = 8,
   parameter int COEF_WIDTH_P = 8,
   parameter int USER_WIDTH_P = 2
) (
   input  wire logic        clk_i,
   input  wire logic        rstn_i,
   rgb2gray_pipe_if.slave   px
);
   localparam int PROD_W = WIDTH_P + COEF_WIDTH_P + 1;
   localparam int SUM_W  = WIDTH_P + COEF_WIDTH_P + 3;
   localparam int RES_W  = SUM_W - COEF_WIDTH_P;

   localparam logic [1:0] MODE_BT601 = 2'd0;
   localparam logic [1:0] MODE_BT709 = 2'd1;
   localparam logic [1:0] MODE_PROG  = 2'd2;
   localparam logic [1:0] MODE_GREEN = 2'd3;

   // Weights are given in units of 1e-4 and rounded to the nearest
   // COEF_WIDTH_P-bit fraction.
   function automatic logic [COEF_WIDTH_P:0] fix_coef(input longint w_e4);
      longint scaled;
      scaled = (w_e4 * (longint'(1) << COEF_WIDTH_P) + 64'sd5000) / 64'sd10000;
      return scaled[COEF_WIDTH_P:0];
   endfunction

   localparam logic [COEF_WIDTH_P:0] BT601_R = fix_coef(64'sd2990);
   localparam logic [COEF_WIDTH_P:0] BT601_G = fix_coef(64'sd5870);
   localparam logic [COEF_WIDTH_P:0] BT601_B = fix_coef(64'sd1140);
   localparam logic [COEF_WIDTH_P:0] BT709_R = fix_coef(64'sd2126);
   localparam logic [COEF_WIDTH_P:0] BT709_G = fix_coef(64'sd7152);
   localparam logic [COEF_WIDTH_P:0] BT709_B = fix_coef(64'sd722);
   localparam logic [COEF_WIDTH_P:0] UNITY   = (COEF_WIDTH_P+1)'(1) << COEF_WIDTH_P;

   localparam logic [SUM_W-1:0]   HALF    = SUM_W'(1) << (COEF_WIDTH_P - 1);
   localparam logic [RES_W-1:0]   MAX_RES = RES_W'((1 << WIDTH_P) - 1);

   // Stage registers
   logic                    s1_valid_q, s1_valid_d;
   logic [PROD_W-1:0]       s1_prod_r_q, s1_prod_r_d;
   logic [PROD_W-1:0]       s1_prod_g_q, s1_prod_g_d;
   logic [PROD_W-1:0]       s1_prod_b_q, s1_prod_b_d;
   logic [1:0]              s1_mode_q, s1_mode_d;
   logic [USER_WIDTH_P-1:0] s1_user_q, s1_user_d;
   logic                    s2_valid_q, s2_valid_d;
   logic [SUM_W-1:0]        s2_sum_q, s2_sum_d;
   logic [USER_WIDTH_P-1:0] s2_user_q, s2_user_d;
   logic                    s3_valid_q, s3_valid_d;
   logic [WIDTH_P-1:0]      s3_gray_q, s3_gray_d;
   logic [USER_WIDTH_P-1:0] s3_user_q, s3_user_d;

   // Combinational helpers
   logic                    s1_en, s2_en, s3_en;
   logic [COEF_WIDTH_P:0]   coef_r, coef_g, coef_b;
   logic [RES_W-1:0]        s3_rounded;

   // A stage may load when it is empty or its successor is taking its
   // contents; this chains ready_i straight through to ready_o.
   assign s3_en = ~s3_valid_q | px.ready_i;
   assign s2_en = ~s2_valid_q | s3_en;
   assign s1_en = ~s1_valid_q | s2_en;

   assign px.ready_o = s1_en;
   assign px.valid_o = s3_valid_q;
   assign px.gray_o  = s3_gray_q;
   assign px.user_o  = s3_user_q;

   always_comb begin
      coef_r = BT601_R;
      coef_g = BT601_G;
      coef_b = BT601_B;
      case (px.mode_i)
         MODE_BT601: begin coef_r = BT601_R;     coef_g = BT601_G;     coef_b = BT601_B;     end
         MODE_BT709: begin coef_r = BT709_R;     coef_g = BT709_G;     coef_b = BT709_B;     end
         MODE_PROG:  begin coef_r = px.coef_r_i; coef_g = px.coef_g_i; coef_b = px.coef_b_i; end
         // Unity green weight: rounding the shifted value back returns green exactly.
         MODE_GREEN: begin coef_r = '0;          coef_g = UNITY;       coef_b = '0;          end
         default:    begin coef_r = BT601_R;     coef_g = BT601_G;     coef_b = BT601_B;     end
      endcase
   end

   // Round half up, then clamp to the output range.
   assign s3_rounded = RES_W'((s2_sum_q + HALF) >> COEF_WIDTH_P);

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_prod_r_d = s1_prod_r_q;
      s1_prod_g_d = s1_prod_g_q;
      s1_prod_b_d = s1_prod_b_q;
      s1_mode_d   = s1_mode_q;
      s1_user_d   = s1_user_q;
      s2_valid_d  = s2_valid_q;
      s2_sum_d    = s2_sum_q;
      s2_user_d   = s2_user_q;
      s3_valid_d  = s3_valid_q;
      s3_gray_d   = s3_gray_q;
      s3_user_d   = s3_user_q;

      if (s1_en) begin
         s1_valid_d = px.valid_i;
         if (px.valid_i) begin
            s1_prod_r_d = PROD_W'(px.red_i)   * PROD_W'(coef_r);
            s1_prod_g_d = PROD_W'(px.green_i) * PROD_W'(coef_g);
            s1_prod_b_d = PROD_W'(px.blue_i)  * PROD_W'(coef_b);
            s1_mode_d   = px.mode_i;
            s1_user_d   = px.user_i;
         end
      end

      if (s2_en) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            if (s1_mode_q == MODE_GREEN)
               s2_sum_d = SUM_W'(s1_prod_g_q);
            else
               s2_sum_d = SUM_W'(s1_prod_r_q) + SUM_W'(s1_prod_g_q) + SUM_W'(s1_prod_b_q);
            s2_user_d = s1_user_q;
         end
      end

      if (s3_en) begin
         s3_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            s3_gray_d = (s3_rounded > MAX_RES) ? '1 : s3_rounded[WIDTH_P-1:0];
            s3_user_d = s2_user_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         s1_valid_q  <= 1'b0;
         s1_prod_r_q <= '0;
         s1_prod_g_q <= '0;
         s1_prod_b_q <= '0;
         s1_mode_q   <= MODE_BT601;
         s1_user_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_sum_q    <= '0;
         s2_user_q   <= '0;
         s3_valid_q  <= 1'b0;
         s3_gray_q   <= '0;
         s3_user_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_prod_r_q <= s1_prod_r_d;
         s1_prod_g_q <= s1_prod_g_d;
         s1_prod_b_q <= s1_prod_b_d;
         s1_mode_q   <= s1_mode_d;
         s1_user_q   <= s1_user_d;
         s2_valid_q  <= s2_valid_d;
         s2_sum_q    <= s2_sum_d;
         s2_user_q   <= s2_user_d;
         s3_valid_q  <= s3_valid_d;
         s3_gray_q   <= s3_gray_d;
         s3_user_q   <= s3_user_d;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_rgb2gray_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgb2gray_pipe
//  Purpose  : Self-checking bench for rgb2gray_pipe. Directed beats carry
//             hand-derived expected values; random traffic is scored against
//             an arithmetic reference of the conversion rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rgb2gray_pipe;
   logic clk;
   logic rstn_i;

   rgb2gray_pipe_if #(.WIDTH_P(8), .COEF_WIDTH_P(8), .USER_WIDTH_P(2)) bus ();

   rgb2gray_pipe #(.WIDTH_P(8), .COEF_WIDTH_P(8), .USER_WIDTH_P(2)) dut (
      .clk_i  (clk),
      .rstn_i (rstn_i),
      .px     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] gray;
      logic [1:0] user;
      int         acc_cyc;
   } exp_t;

   exp_t sb[$];
   int   tests     = 0;
   int   fails     = 0;
   int   cyc       = 0;
   int   pend_exp  = -1;
   bit   chk_lat   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: weighted sum in plain integers, round half up, clamp.
   function automatic int ref_gray(input int r, g, b, m, cr, cg, cb);
      int wr, wg, wb, s, q;
      case (m)
         0:       begin wr = 77; wg = 150; wb = 29; end
         1:       begin wr = 54; wg = 183; wb = 18; end
         2:       begin wr = cr; wg = cg;  wb = cb; end
         default: return g;
      endcase
      s = r * wr + g * wg + b * wb;
      q = (s + 128) / 256;
      return (q > 255) ? 255 : q;
   endfunction

   // One cycle: settle, observe handshakes at mid-low-phase, score, advance.
   task automatic tick(output bit acc);
      bit   emit;
      exp_t e;
      #1;
      acc  = rstn_i && bus.valid_i && bus.ready_o;
      emit = rstn_i && bus.valid_o && bus.ready_i;
      if (emit) begin
         if (sb.size() == 0) begin
            check("unexpected_beat", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("gray", bus.gray_o, e.gray);
            check("user", bus.user_o, e.user);
            if (chk_lat) check("latency", cyc - e.acc_cyc, 3);
         end
      end
      if (acc) begin
         e.gray    = (pend_exp >= 0) ? 8'(pend_exp)
                   : 8'(ref_gray(bus.red_i, bus.green_i, bus.blue_i, bus.mode_i,
                                 bus.coef_r_i, bus.coef_g_i, bus.coef_b_i));
         e.user    = bus.user_i;
         e.acc_cyc = cyc;
         sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic set_pix(input int r, g, b, m, cr, cg, cb, u, ex);
      bus.red_i    = 8'(r);
      bus.green_i  = 8'(g);
      bus.blue_i   = 8'(b);
      bus.mode_i   = 2'(m);
      bus.coef_r_i = 9'(cr);
      bus.coef_g_i = 9'(cg);
      bus.coef_b_i = 9'(cb);
      bus.user_i   = 2'(u);
      pend_exp     = ex;
   endtask

   task automatic beat(input int r, g, b, m, cr, cg, cb, u, ex);
      bit acc;
      int n;
      n = 0;
      set_pix(r, g, b, m, cr, cg, cb, u, ex);
      bus.valid_i = 1'b1;
      do begin
         tick(acc);
         n++;
      end while (!acc && n < 20);
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
      bus.valid_i = 1'b0;
   endtask

   // Idle cycles scramble the non-valid inputs so later beats prove that
   // only values present at acceptance matter.
   task automatic idle(input int n);
      bit acc;
      bus.valid_i = 1'b0;
      for (int i = 0; i < n; i++) begin
         set_pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 3), $urandom_range(0, 511), $urandom_range(0, 511),
                 $urandom_range(0, 511), $urandom_range(0, 3), -1);
         tick(acc);
      end
   endtask

   initial begin
      bit acc;
      int k;
      int accepted;
      int guard;

      rstn_i = 1'b1;
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      set_pix(0, 0, 0, 0, 0, 0, 0, 0, -1);
      #1 rstn_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_valid_o", bus.valid_o, 0);
      check("rst_gray_o",  bus.gray_o,  0);
      check("rst_user_o",  bus.user_o,  0);
      check("rst_ready_o", bus.ready_o, 1);
      @(negedge clk);
      rstn_i = 1'b1;
      idle(2);

      // BT.601 back-to-back with exact 3-cycle latency.
      chk_lat = 1'b1;
      beat(255,   0,   0, 0, 0, 0, 0, 1, 77);
      beat(  0, 255,   0, 0, 0, 0, 0, 2, 149);
      beat(255, 255, 255, 0, 0, 0, 0, 3, 255);
      idle(5);
      check("bt601_drained", sb.size(), 0);

      // BT.709, green passthrough, and per-beat mode alternation.
      beat(100, 200,  50, 1, 0, 0, 0, 0, 168);
      beat( 12, 200,   7, 3, 0, 0, 0, 1, 200);
      beat(200, 100,  50, 0, 0, 0, 0, 2, 124);
      beat(200, 100,  50, 1, 0, 0, 0, 3, 117);
      beat(200, 100,  50, 0, 0, 0, 0, 0, 124);
      beat(200, 100,  50, 1, 0, 0, 0, 1, 117);
      idle(5);

      // Programmable weights: saturation, half rounding up, late coef change.
      beat(255, 255, 255, 2, 255, 255, 255, 2, 255);
      beat(  3,   0,   0, 2, 128,   0,   0, 3, 2);
      set_pix(3, 0, 0, 2, 511, 511, 511, 0, -1);
      idle(5);
      check("prog_drained", sb.size(), 0);

      // Backpressure: six beats offered with the sink stalled.
      chk_lat = 1'b0;
      bus.ready_i = 1'b0;
      k = 0;
      for (int c = 0; c < 6; c++) begin
         set_pix(0, 10 + k, 0, 3, 0, 0, 0, k % 4, 10 + k);
         bus.valid_i = 1'b1;
         tick(acc);
         if (acc) k++;
      end
      check("bp_accepted", k, 3);
      check("bp_ready_low", bus.ready_o, 0);
      check("bp_valid_held", bus.valid_o, 1);
      check("bp_gray_held", bus.gray_o, 10);
      tick(acc);
      tick(acc);
      check("bp_gray_stable", bus.gray_o, 10);
      check("bp_user_stable", bus.user_o, 0);
      bus.ready_i = 1'b1;
      guard = 0;
      while ((k < 6 || sb.size() != 0) && guard < 30) begin
         if (k < 6) begin
            set_pix(0, 10 + k, 0, 3, 0, 0, 0, k % 4, 10 + k);
            bus.valid_i = 1'b1;
         end else begin
            bus.valid_i = 1'b0;
         end
         tick(acc);
         if (acc) k++;
         guard++;
      end
      bus.valid_i = 1'b0;
      check("bp_all_sent", k, 6);
      check("bp_drained", sb.size(), 0);

      // Random traffic against the reference model.
      accepted = 0;
      guard = 0;
      while (accepted < 10000 && guard < 60000) begin
         set_pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 3), $urandom_range(0, 511), $urandom_range(0, 511),
                 $urandom_range(0, 511), $urandom_range(0, 3), -1);
         bus.valid_i = ($urandom_range(0, 3) != 0);
         bus.ready_i = ($urandom_range(0, 3) != 0);
         tick(acc);
         if (acc) accepted++;
         guard++;
      end
      check("rand_accepted", accepted, 10000);
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      guard = 0;
      while (sb.size() != 0 && guard < 20) begin
         tick(acc);
         guard++;
      end
      check("rand_drained", sb.size(), 0);

      // Reset with two beats in flight.
      chk_lat = 1'b1;
      beat(255,   0,   0, 0, 0, 0, 0, 1, 77);
      beat(255, 255, 255, 0, 0, 0, 0, 2, 255);
      rstn_i = 1'b0;
      #1;
      check("midrst_valid_o", bus.valid_o, 0);
      check("midrst_gray_o",  bus.gray_o,  0);
      check("midrst_user_o",  bus.user_o,  0);
      sb.delete();
      tick(acc);
      tick(acc);
      rstn_i = 1'b1;
      beat(0, 255, 0, 0, 0, 0, 0, 3, 149);
      idle(6);
      check("post_rst_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog so the bench always ends on its own.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
